// File: rtl/pulse_timer_pkg.sv
// Shared types for the multi-channel pulse/timer engine.
package pulse_timer_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF      = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_RETRIG   = 2'd2,
        MODE_PERIODIC = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/pulse_timer_ch.sv
// One timer channel: trigger edge detect, shadow/active period and width,
// phase counter and the IDLE/RUN controller.
module pulse_timer_ch
    import pulse_timer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic              trig,
    input  logic              stop,
    output logic              pulse_out,
    output logic              busy,
    output logic              done
);

    state_e             state_q;
    state_e             state_d;
    mode_e              mode_q;
    mode_e              mode_new;
    logic [CNT_W-1:0]   period_sh;
    logic [CNT_W-1:0]   width_sh;
    logic [CNT_W-1:0]   period_act;
    logic [CNT_W-1:0]   width_act;
    logic [CNT_W-1:0]   period_new;
    logic [CNT_W-1:0]   width_new;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               trig_q;
    logic               trig_edge;
    logic               mode_change;
    logic               start;
    logic               load_act;
    logic               pulse_q;
    logic               pulse_d;
    logic               done_q;
    logic               done_d;

    // A write in the same cycle as a trigger or wrap is seen through this bypass.
    assign mode_new    = cfg_we ? mode_e'(cfg_mode) : mode_q;
    assign period_new  = cfg_we ? cfg_period : period_sh;
    assign width_new   = cfg_we ? cfg_width : width_sh;
    assign mode_change = cfg_we && (mode_e'(cfg_mode) != mode_q);
    assign trig_edge   = trig && !trig_q;
    assign cnt_inc     = cnt_q + 1'b1;

    assign start = trig_edge &&
                   ((mode_new == MODE_PERIODIC) ||
                    (mode_new == MODE_RETRIG) ||
                    ((mode_new == MODE_ONESHOT) && (state_q == ST_IDLE)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pulse_d  = pulse_q;
        done_d   = 1'b0;
        load_act = 1'b0;
        if (stop || ((state_q == ST_RUN) && mode_change)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pulse_d = 1'b0;
        end else if (start) begin
            load_act = 1'b1;
            if (mode_new == MODE_PERIODIC) begin
                state_d = ST_RUN;
                cnt_d   = '0;
                pulse_d = (width_new != '0);
            end else if (width_new == '0) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                pulse_d = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
                cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                pulse_d = 1'b1;
            end
        end else if (state_q == ST_RUN) begin
            // Counting stops at period/width itself, so the full range never overflows.
            if (mode_q == MODE_PERIODIC) begin
                if (cnt_q == period_act) begin
                    load_act = 1'b1;
                    cnt_d    = '0;
                    pulse_d  = (width_new != '0);
                end else begin
                    cnt_d   = cnt_inc;
                    pulse_d = (cnt_inc < width_act);
                end
            end else if (cnt_q >= width_act) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                pulse_d = 1'b0;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_inc;
            end
        end else begin
            cnt_d   = '0;
            pulse_d = 1'b0;
        end
    end

    always_comb begin
        busy      = (state_q == ST_RUN);
        pulse_out = pulse_q;
        done      = done_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= MODE_OFF;
            period_sh  <= '0;
            width_sh   <= '0;
            period_act <= '0;
            width_act  <= '0;
            cnt_q      <= '0;
            trig_q     <= 1'b0;
            pulse_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            trig_q  <= trig;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
            if (cfg_we) begin
                mode_q    <= mode_e'(cfg_mode);
                period_sh <= cfg_period;
                width_sh  <= cfg_width;
            end
            if (load_act) begin
                period_act <= period_new;
                width_act  <= width_new;
            end
        end
    end

endmodule

// File: rtl/pulse_timer_nch.sv
// Multi-channel pulse/timer engine: shared config port fanned out to NCH
// independent channels.
module pulse_timer_nch
    import pulse_timer_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 8,
    parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [NCH-1:0]    trig,
    input  logic [NCH-1:0]    stop,
    output logic [NCH-1:0]    pulse_out,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    done
);

    logic [NCH-1:0] ch_we;

    // Selects beyond NCH-1 match no channel and are dropped.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));

        pulse_timer_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .cfg_we    (ch_we[i]),
            .cfg_mode  (cfg_mode),
            .cfg_period(cfg_period),
            .cfg_width (cfg_width),
            .trig      (trig[i]),
            .stop      (stop[i]),
            .pulse_out (pulse_out[i]),
            .busy      (busy[i]),
            .done      (done[i])
        );
    end

endmodule
